// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier and its ALU.
// Holds the FSM encoding, the ALU opcode used for the add step and the iteration count.
package alu_mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] ALUC_ADD  = 2'b00;
   localparam logic [1:0] ALUC_SUB  = 2'b01;
   localparam logic [1:0] ALUC_AND  = 2'b10;
   localparam logic [1:0] ALUC_OR   = 2'b11;
   localparam int         MUL_ITERS = 32;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Datapath ALU: 32-bit add/sub/and/or with zero and signed-overflow flags.
// Reused unchanged by the multiplier, which only drives the add opcode.
module alu_mul_seq_alu
   import alu_mul_seq_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [1:0]  aluc,
   output logic [31:0] r,
   output logic        z,
   output logic        v
);

   always_comb begin
      r = 32'd0;
      v = 1'b0;
      case (aluc)
         ALUC_ADD: begin
            r = x + y;
            v = (x[31] == y[31]) && (r[31] != x[31]);
         end
         ALUC_SUB: begin
            r = x - y;
            v = (x[31] != y[31]) && (r[31] != x[31]);
         end
         ALUC_AND: r = x & y;
         ALUC_OR:  r = x | y;
         default:  r = 32'd0;
      endcase
      z = (r == 32'd0);
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 multiplier: one shift-add step per clock through the shared ALU.
// Fixed 32-iteration latency; start/busy/done handshake toward the control unit.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Z,
   output logic             Ovf,
   output logic [1:0]       dbg_state
);

   // Handshake: Start is taken only in IDLE; Busy marks ITER, Done is a one-cycle
   // result-valid pulse, and Start seen while Busy or Done is dropped, not queued.

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_z_unused;
   logic               alu_v_unused;
   logic               carry;
   logic               last_iter;
   logic [WIDTH-1:0]   hi_nxt;
   logic [WIDTH-1:0]   lo_nxt;

   alu_mul_seq_alu u_alu (
      .x    (Hi),
      .y    (mcand),
      .aluc (ALUC_ADD),
      .r    (alu_r),
      .z    (alu_z_unused),
      .v    (alu_v_unused)
   );

   assign last_iter = (count == CNT_W'(MUL_ITERS - 1));
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: if (Start) state_nxt = ITER;
         ITER: begin
            Busy = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The ALU sum is only 32 bits; the carry out is rebuilt from the operand and sum MSBs.
   always_comb begin
      carry = (Hi[WIDTH-1] & mcand[WIDTH-1]) |
              ((Hi[WIDTH-1] | mcand[WIDTH-1]) & ~alu_r[WIDTH-1]);
      if (Lo[0]) begin
         hi_nxt = {carry, alu_r[WIDTH-1:1]};
         lo_nxt = {alu_r[0], Lo[WIDTH-1:1]};
      end else begin
         hi_nxt = {1'b0, Hi[WIDTH-1:1]};
         lo_nxt = {Hi[0], Lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         count <= '0;
         mcand <= '0;
         Hi    <= '0;
         Lo    <= '0;
         Z     <= 1'b0;
         Ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (Start) begin
                  mcand <= A;
                  Hi    <= '0;
                  Lo    <= B;
                  count <= '0;
               end
            end
            ITER: begin
               Hi    <= hi_nxt;
               Lo    <= lo_nxt;
               count <= count + 1'b1;
               // Flags come from the final product so they land with Done, no extra cycle.
               if (last_iter) begin
                  Z   <= ({hi_nxt, lo_nxt} == '0);
                  Ovf <= (hi_nxt != '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: driver issues operations and queues the
// reference product; a negedge monitor pops and checks each Done pulse.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        z;
   logic        ovf;
   logic [1:0]  dbg_state;

   logic [65:0] exp_q[$];
   int          acc_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic        prev_done = 1'b0;

   alu_mul_seq dut (
      .Clk       (clk),
      .Rst       (rst),
      .Start     (start),
      .A         (a_in),
      .B         (b_in),
      .Busy      (busy),
      .Done      (done),
      .Hi        (hi),
      .Lo        (lo),
      .Z         (z),
      .Ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout at cycle %0d, expected summary before it", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [65:0] e;
      int          acc;
      if (done) begin
         check("done_single_pulse", {63'd0, prev_done}, 64'd0);
         check("busy_low_at_done", {63'd0, busy}, 64'd0);
         if (exp_q.size() == 0) begin
            check("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            e   = exp_q.pop_front();
            acc = acc_q.pop_front();
            check("hi",  {32'd0, hi}, {32'd0, e[63:32]});
            check("lo",  {32'd0, lo}, {32'd0, e[31:0]});
            check("z",   {63'd0, z},   {63'd0, e[64]});
            check("ovf", {63'd0, ovf}, {63'd0, e[65]});
            // Done is the cycle following the 32nd iteration edge after the accept edge.
            check("latency", 64'(cyc - acc), 64'd32);
         end
      end
      prev_done = done;
   end

   // ---------------- driver ----------------
   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit expect_done,
                         input int repulse_at, input int rst_at);
      logic [63:0] prod;
      int          acc;
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      #1;
      acc   = cyc;
      start = 1'b0;
      a_in  = $urandom;
      b_in  = $urandom;
      prod  = {32'd0, a} * {32'd0, b};
      if (expect_done) begin
         exp_q.push_back({(prod[63:32] != 32'd0), (prod == 64'd0), prod});
         acc_q.push_back(acc);
      end
      @(negedge clk);
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      for (int n = 1; n <= 33; n++) begin
         @(negedge clk);
         if (n == repulse_at) begin
            start = 1'b1;
            a_in  = $urandom;
            b_in  = $urandom;
         end else begin
            start = 1'b0;
         end
         if (n == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_busy",  {63'd0, busy}, 64'd0);
            check("rst_done",  {63'd0, done}, 64'd0);
            check("rst_hi",    {32'd0, hi}, 64'd0);
            check("rst_lo",    {32'd0, lo}, 64'd0);
            check("rst_z",     {63'd0, z}, 64'd0);
            check("rst_ovf",   {63'd0, ovf}, 64'd0);
            check("rst_state", {62'd0, dbg_state}, 64'd0);
            rst = 1'b0;
            return;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hi",   {32'd0, hi}, 64'd0);
      check("reset_lo",   {32'd0, lo}, 64'd0);
      check("reset_z",    {63'd0, z}, 64'd0);
      check("reset_ovf",  {63'd0, ovf}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Start coinciding with reset must be dropped.
      rst   = 1'b1;
      start = 1'b1;
      a_in  = 32'd9;
      b_in  = 32'd9;
      @(negedge clk);
      check("rst_start_busy",  {63'd0, busy}, 64'd0);
      check("rst_start_state", {62'd0, dbg_state}, 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_no_busy", {63'd0, busy}, 64'd0);

      run_op(32'd3, 32'd5, 1'b1, 0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);
      run_op(32'd0, 32'h1234_5678, 1'b1, 0, 0);
      run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 0, 0);
      run_op(32'd100, 32'd200, 1'b1, 10, 0);
      run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0, 16);
      run_op(32'd7, 32'd6, 1'b1, 0, 0);

      for (int i = 0; i < 1000; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         case ($urandom_range(0, 9))
            0:       ra = 32'd0;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
         run_op(ra, rb, 1'b1, (i % 7 == 0) ? $urandom_range(1, 30) : 0, 0);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
